spi_pixel_rx: RTL
=================

# spi_pixel_rx

SPI-slave pixel receiver feeding the Rx frame memory. Deserializes an SPI stream (MSB first, mode 0) sampled in the `Cclk` domain into 12-bit pixel words with a running write address. It emits the `SPIDataValid`/`SPIData`/`SPIDataAdd` write strobe and the `FraimSel` frame-select control that the downstream memory stage consumes. It also decodes frame-select commands and counts protocol errors.

## Interface
Parameters:
- `MEM_DEPTH`, 38400: pixel words per frame buffer; the address wraps at `MEM_DEPTH-1`.
- `CMD_PIX`, 8'hA5: command byte for a pixel burst.

Ports:
- `Cclk`  in  1  System clock; the single clock of the block.
- `rst`  in  1  Reset, synchronous, active-high.
- `SCLK`  in  1  SPI clock, asynchronous to `Cclk`.
- `CS_n`  in  1  SPI chip select, active-low, asynchronous.
- `MOSI`  in  1  SPI data, asynchronous.
- `SPIDataValid`  out  1  One-cycle pixel write strobe.
- `SPIData`  out  12  Pixel word. Valid while `SPIDataValid` is high; holds its value otherwise.
- `SPIDataAdd`  out  16  Write address for `SPIData`.
- `FraimSel`  out  2  Frame-select control. Holds its last commanded value.
- `ErrCnt`  out  8  Protocol error count. Saturates at 8'hFF.
- `Busy`  out  1  High whenever the FSM is not in IDLE.

## Operation
- `SCLK`, `CS_n` and `MOSI` each pass through a 2-FF synchronizer. `SCLK` rise is detected from the synchronized value and the previous synchronized value.
- `MOSI` is sampled only on a detected `SCLK` rise while synchronized `CS_n` is 0. Bits shift in MSB first.
- FSM states: IDLE, CMD, ADDR, DATA, DROP.
  - IDLE -> CMD when synchronized `CS_n` falls. The bit counter clears on entry.
  - CMD (8 bits), then decode the byte:
    - `CMD_PIX` -> ADDR.
    - 8'hF3 -> `FraimSel` = 2'b11, go to DROP.
    - 8'hF2 -> `FraimSel` = 2'b10, go to DROP.
    - 8'hF0 -> `FraimSel` = 2'b00, go to DROP.
    - Any other byte -> `ErrCnt`++, go to DROP.
  - ADDR (16 bits), then load the address counter:
    - Value < `MEM_DEPTH` -> DATA.
    - Otherwise -> `ErrCnt`++, go to DROP.
  - DATA: every 12 bits (13 bits with parity enabled, see Configuration), issue one write, then advance the address. After `MEM_DEPTH-1` the address wraps to 0.
  - DROP: ignore all bits until `CS_n` rises.
- A synchronized `CS_n` rise in any state forces IDLE.
  - A partial CMD, ADDR or DATA word is discarded without a write.
  - A partial CMD or ADDR also increments `ErrCnt`. A partial DATA word does not count as an error.
- `CS_n` rise and a final-bit `SCLK` rise detected in the same `Cclk` cycle: the bit is taken and the word completes normally, then the FSM goes to IDLE.
- `ErrCnt` saturates at 255. Only `rst` clears it.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `SPIDataValid` = 0, `SPIData` = 0, `SPIDataAdd` = 0.
  - `FraimSel` = 2'b00, `ErrCnt` = 0, `Busy` = 0, FSM = IDLE.
  - Synchronizer flops reset to `SCLK` = 0, `CS_n` = 1, `MOSI` = 0.
- `rst` asserted mid-burst aborts immediately. No write is issued in or after the reset cycle.
- Latency:
  - A pin edge appears at the synchronizer output after 2 `Cclk` cycles, and the edge is detected on the 3rd.
  - `SPIDataValid` rises in the `Cclk` cycle after the edge-detect cycle of a word's last bit: 4 `Cclk` cycles after the pin `SCLK` rise.
  - `SPIData` and `SPIDataAdd` are registered together with `SPIDataValid`.
  - The address advances in the cycle after the strobe.
- `FraimSel` updates 1 cycle after the command's 8th-bit edge detect.
- `SCLK` high and low phases must each be at least 4 `Cclk` periods. Behaviour is not defined for faster `SCLK`.
- `SPIDataValid` is never high for two consecutive cycles.

## Configuration
- `SPIRX_PARITY_EN` defined:
  - Each DATA word is 13 bits: 12 data bits followed by 1 even-parity bit over those 12 bits.
  - On a parity mismatch: no strobe, `ErrCnt`++, and the address still advances so the following pixels keep their position.
- `SPIRX_PARITY_EN` undefined: DATA words are 12 bits and no parity is checked.

## Test plan
- Pixel burst: send A5, addr 0x0010, pixels 0xABC and 0x123. Expect two strobes: (0x0010, 0xABC) then (0x0011, 0x123). `ErrCnt` = 0.
- Address wrap: send A5, addr 0x95FF, three pixels. Expect writes at addresses 0x95FF, 0x0000, 0x0001.
- Frame select: send F3 -> `FraimSel` = 11. Send F2 -> 10. Send F0 -> 00. Send 0x77 -> `FraimSel` stays 00 and `ErrCnt` = 1.
- Bad address and abort:
  - A5 with addr 0x9600 -> no strobes, `ErrCnt`++.
  - `CS_n` raised after 7 bits of a pixel -> no strobe, `ErrCnt` unchanged.
- Reset mid-burst: assert `rst` after 6 bits of a pixel. Expect all outputs at reset values and no strobe. Then send A5/0x0000/0xFFF -> single write (0x0000, 0xFFF).
- Parity, with `SPIRX_PARITY_EN`: pixels 0x0F0 (parity 0, good), then 0x001 with a wrong parity bit, then 0x002 (parity 1, good), starting at addr 5.
  - Expect writes at 5 and 7 only, and `ErrCnt` = 1.

Source files
------------

// File: rtl/spi_pixel_rx_if.sv
//==============================================================================
// Module      : spi_pixel_rx_if
// Description : SPI pin bundle plus pixel-write/status outputs of spi_pixel_rx.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface spi_pixel_rx_if;
    logic        SCLK;
    logic        CS_n;
    logic        MOSI;
    logic        SPIDataValid;
    logic [11:0] SPIData;
    logic [15:0] SPIDataAdd;
    logic [1:0]  FraimSel;
    logic [7:0]  ErrCnt;
    logic        Busy;

    modport master (
        output SCLK, CS_n, MOSI,
        input  SPIDataValid, SPIData, SPIDataAdd, FraimSel, ErrCnt, Busy
    );

    modport slave (
        input  SCLK, CS_n, MOSI,
        output SPIDataValid, SPIData, SPIDataAdd, FraimSel, ErrCnt, Busy
    );
endinterface

`default_nettype wire

// File: rtl/spi_pixel_rx.sv
//==============================================================================
// Module      : spi_pixel_rx
// Description : SPI-slave (mode 0, MSB first) pixel receiver with frame-select
//               command decode and error counting. Optional per-pixel even
//               parity is enabled by defining SPIRX_PARITY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module spi_pixel_rx #(
    parameter int unsigned MEM_DEPTH = 38400,
    parameter logic [7:0]  CMD_PIX   = 8'hA5
) (
    input  logic          Cclk,
    input  logic          rst,
    spi_pixel_rx_if.slave bus
);

`ifdef SPIRX_PARITY_EN
    localparam logic [4:0] C_DATA_BITS = 5'd13;
`else
    localparam logic [4:0] C_DATA_BITS = 5'd12;
`endif
    localparam logic [15:0] C_LAST_ADDR = 16'(MEM_DEPTH - 1);
    localparam logic [16:0] C_DEPTH     = 17'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    // Synchronizer and edge-detect stage
    logic r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic r_cs_meta,   r_cs_sync,   r_cs_prev;
    logic r_mosi_meta, r_mosi_sync;
    logic r_sclk_rise, r_cs_rise, r_cs_fall, r_cs_was_low, r_mosi_s;

    // FSM and datapath
    state_t      r_state, w_state_next;
    logic [14:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic [15:0] r_addr;
    logic        r_adv;
    logic        r_valid;
    logic [11:0] r_data;
    logic [15:0] r_data_add;
    logic [1:0]  r_fsel;
    logic [7:0]  r_err;

    logic        w_bit;
    logic [15:0] w_shift_in;
    logic [4:0]  w_cnt_inc;
    logic [4:0]  w_len;
    logic        w_done;
    logic [11:0] w_pix;
    logic        w_pix_ok;
    logic        w_shift_en;
    logic        w_cnt_clr;
    logic        w_write;
    logic        w_adv;
    logic        w_err_inc;
    logic        w_fsel_load;
    logic [1:0]  w_fsel_val;
    logic        w_addr_load;

    always_ff @(posedge Cclk) begin
        if (rst) begin
            r_sclk_meta  <= 1'b0;
            r_sclk_sync  <= 1'b0;
            r_sclk_prev  <= 1'b0;
            r_cs_meta    <= 1'b1;
            r_cs_sync    <= 1'b1;
            r_cs_prev    <= 1'b1;
            r_mosi_meta  <= 1'b0;
            r_mosi_sync  <= 1'b0;
            r_sclk_rise  <= 1'b0;
            r_cs_rise    <= 1'b0;
            r_cs_fall    <= 1'b0;
            r_cs_was_low <= 1'b0;
            r_mosi_s     <= 1'b0;
        end else begin
            r_sclk_meta  <= bus.SCLK;
            r_sclk_sync  <= r_sclk_meta;
            r_sclk_prev  <= r_sclk_sync;
            r_cs_meta    <= bus.CS_n;
            r_cs_sync    <= r_cs_meta;
            r_cs_prev    <= r_cs_sync;
            r_mosi_meta  <= bus.MOSI;
            r_mosi_sync  <= r_mosi_meta;
            r_sclk_rise  <= r_sclk_sync & ~r_sclk_prev;
            r_cs_rise    <= r_cs_sync & ~r_cs_prev;
            r_cs_fall    <= ~r_cs_sync & r_cs_prev;
            // Chip select as seen before any rise in this cycle, so a final
            // bit coinciding with CS_n release is still accepted.
            r_cs_was_low <= ~r_cs_prev;
            r_mosi_s     <= r_mosi_sync;
        end
    end

    assign w_bit      = r_sclk_rise & r_cs_was_low;
    assign w_shift_in = {r_shift, r_mosi_s};
    assign w_cnt_inc  = r_bit_cnt + 5'd1;
    assign w_done     = w_bit && (w_cnt_inc == w_len);

`ifdef SPIRX_PARITY_EN
    assign w_pix    = w_shift_in[12:1];
    assign w_pix_ok = ~(^w_shift_in[12:0]);
`else
    assign w_pix    = w_shift_in[11:0];
    assign w_pix_ok = 1'b1;
`endif

    always_comb begin
        w_len = 5'd0;
        case (r_state)
            ST_CMD:  w_len = 5'd8;
            ST_ADDR: w_len = 5'd16;
            ST_DATA: w_len = C_DATA_BITS;
            default: w_len = 5'd0;
        endcase
    end

    always_ff @(posedge Cclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_cnt_clr    = 1'b0;
        w_write      = 1'b0;
        w_adv        = 1'b0;
        w_err_inc    = 1'b0;
        w_fsel_load  = 1'b0;
        w_fsel_val   = 2'b00;
        w_addr_load  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_cs_fall) begin
                    w_state_next = ST_CMD;
                    w_cnt_clr    = 1'b1;
                end
            end
            ST_CMD: begin
                w_shift_en = w_bit;
                if (w_done) begin
                    w_cnt_clr = 1'b1;
                    if (w_shift_in[7:0] == CMD_PIX) begin
                        w_state_next = ST_ADDR;
                    end else begin
                        w_state_next = ST_DROP;
                        case (w_shift_in[7:0])
                            8'hF3: begin w_fsel_load = 1'b1; w_fsel_val = 2'b11; end
                            8'hF2: begin w_fsel_load = 1'b1; w_fsel_val = 2'b10; end
                            8'hF0: begin w_fsel_load = 1'b1; w_fsel_val = 2'b00; end
                            default: w_err_inc = 1'b1;
                        endcase
                    end
                end else if (r_cs_rise) begin
                    w_err_inc = 1'b1;
                end
            end
            ST_ADDR: begin
                w_shift_en = w_bit;
                if (w_done) begin
                    w_cnt_clr = 1'b1;
                    if ({1'b0, w_shift_in} < C_DEPTH) begin
                        w_addr_load  = 1'b1;
                        w_state_next = ST_DATA;
                    end else begin
                        w_err_inc    = 1'b1;
                        w_state_next = ST_DROP;
                    end
                end else if (r_cs_rise) begin
                    w_err_inc = 1'b1;
                end
            end
            ST_DATA: begin
                w_shift_en = w_bit;
                if (w_done) begin
                    w_cnt_clr = 1'b1;
                    // A bad-parity pixel still consumes its address slot.
                    w_adv     = 1'b1;
                    w_write   = w_pix_ok;
                    w_err_inc = ~w_pix_ok;
                end
            end
            ST_DROP: begin
                w_state_next = ST_DROP;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if ((r_state != ST_IDLE) && r_cs_rise) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge Cclk) begin
        if (rst) begin
            r_shift    <= 15'd0;
            r_bit_cnt  <= 5'd0;
            r_addr     <= 16'd0;
            r_adv      <= 1'b0;
            r_valid    <= 1'b0;
            r_data     <= 12'd0;
            r_data_add <= 16'd0;
            r_fsel     <= 2'b00;
            r_err      <= 8'd0;
        end else begin
            if (w_shift_en) begin
                r_shift <= w_shift_in[14:0];
            end
            if (w_cnt_clr) begin
                r_bit_cnt <= 5'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= w_cnt_inc;
            end
            if (w_addr_load) begin
                r_addr <= w_shift_in;
            end else if (r_adv) begin
                r_addr <= (r_addr == C_LAST_ADDR) ? 16'd0 : r_addr + 16'd1;
            end
            r_adv   <= w_adv;
            r_valid <= w_write;
            if (w_write) begin
                r_data     <= w_pix;
                r_data_add <= r_addr;
            end
            if (w_fsel_load) begin
                r_fsel <= w_fsel_val;
            end
            if (w_err_inc && (r_err != 8'hFF)) begin
                r_err <= r_err + 8'd1;
            end
        end
    end

    assign bus.SPIDataValid = r_valid;
    assign bus.SPIData      = r_data;
    assign bus.SPIDataAdd   = r_data_add;
    assign bus.FraimSel     = r_fsel;
    assign bus.ErrCnt       = r_err;
    assign bus.Busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire
